// File: rtl/ace_snoop_port.sv
// ACE snoop port: queues AC snoop requests, looks each one up in the local
// cache, returns the CR response and, when data is transferred, streams the
// cache line on CD. Requests are serviced one at a time in arrival order.
//
// state  | meaning
// IDLE   | waiting for a queued request
// LOOKUP | head request presented to the cache (skipped for unsupported types)
// WAIT   | waiting for the cache lookup result
// RESP   | CR response presented until accepted
// DATA   | CD beats streamed, beat 0 first
module ace_snoop_port #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LINE_BEATS  = 4,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             acvalid,
  output logic                             acready,
  input  logic [ADDR_WIDTH-1:0]            acaddr,
  input  logic [3:0]                       acsnoop,
  input  logic [2:0]                       acprot,
  output logic                             crvalid,
  input  logic                             crready,
  output logic [4:0]                       crresp,
  output logic                             cdvalid,
  input  logic                             cdready,
  output logic [DATA_WIDTH-1:0]            cddata,
  output logic                             cdlast,
  output logic                             lk_valid,
  input  logic                             lk_ready,
  output logic [ADDR_WIDTH-1:0]            lk_addr,
  output logic [3:0]                       lk_snoop,
  input  logic                             lk_rsp_valid,
  input  logic                             lk_hit,
  input  logic                             lk_dirty,
  input  logic                             lk_unique,
  input  logic [DATA_WIDTH*LINE_BEATS-1:0] lk_line
);

  localparam int OFF    = $clog2(LINE_BEATS * DATA_WIDTH / 8);
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WAIT, S_RESP, S_DATA} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] q_addr  [QUEUE_DEPTH];
  logic [3:0]            q_snoop [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, empty, push, pop;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [3:0]            cur_snoop;
  logic [4:0]            resp_q, resp_d;
  logic [LINE_BEATS-1:0][DATA_WIDTH-1:0] line_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  supported, is_read, is_clean, shared_type;
  logic                  dt, pd;
  logic                  unused_sig;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(QUEUE_DEPTH));
  assign empty   = (count == '0);
  // acready is forced low while the port is held in reset
  assign acready = rst_n && !full;
  assign push    = acvalid && acready;
  assign pop     = (state_q == S_IDLE) && !empty;

  // protection bits and the in-line offset play no part in snooping
  assign unused_sig = ^{acprot, cur_addr[OFF-1:0]};

  // FIFO storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= acaddr;
      q_snoop[wr_ptr] <= acsnoop;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // snoop type classification and response bits from the lookup result
  always_comb begin
    is_read     = (cur_snoop == 4'b0000) || (cur_snoop == 4'b0001) ||
                  (cur_snoop == 4'b0010) || (cur_snoop == 4'b0011) ||
                  (cur_snoop == 4'b0111);
    is_clean    = (cur_snoop == 4'b1000) || (cur_snoop == 4'b1001);
    supported   = is_read || is_clean || (cur_snoop == 4'b1101);
    shared_type = (cur_snoop == 4'b0000) || (cur_snoop == 4'b0001) ||
                  (cur_snoop == 4'b0010) || (cur_snoop == 4'b0011) ||
                  (cur_snoop == 4'b1000);
    dt = 1'b0;
    if (is_read)       dt = lk_hit;
    else if (is_clean) dt = lk_hit && lk_dirty;
    // ReadOnce and ReadClean never hand over dirty ownership
    pd = dt && lk_dirty && (cur_snoop != 4'b0000) && (cur_snoop != 4'b0010);
    resp_d = {lk_hit && lk_unique, lk_hit && shared_type, pd, 1'b0, dt};
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!empty) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (!supported)    state_d = S_RESP;
        else if (lk_ready) state_d = S_WAIT;
      end
      S_WAIT:   if (lk_rsp_valid) state_d = S_RESP;
      S_RESP:   if (crready) state_d = resp_q[0] ? S_DATA : S_IDLE;
      S_DATA:   if (cdready && (beat_q == LAST_BEAT)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // output decode
  always_comb begin
    lk_valid = (state_q == S_LOOKUP) && supported;
    crvalid  = (state_q == S_RESP);
    crresp   = (state_q == S_RESP) ? resp_q : 5'b00000;
    cdvalid  = (state_q == S_DATA);
    cdlast   = (state_q == S_DATA) && (beat_q == LAST_BEAT);
    cddata   = (state_q == S_DATA) ? line_q[beat_q] : '0;
  end

  assign lk_addr  = {cur_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
  assign lk_snoop = cur_snoop;

  // request, response and line capture plus the CD beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      cur_snoop <= '0;
      resp_q    <= '0;
      line_q    <= '0;
      beat_q    <= '0;
    end else begin
      if (pop) begin
        cur_addr  <= q_addr[rd_ptr];
        cur_snoop <= q_snoop[rd_ptr];
      end
      if ((state_q == S_LOOKUP) && !supported) resp_q <= 5'b00000;
      if ((state_q == S_WAIT) && lk_rsp_valid) begin
        resp_q <= resp_d;
        line_q <= lk_line;
      end
      if ((state_q == S_DATA) && cdready)
        beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ace_snoop_port.sv
// Directed bench for ace_snoop_port: stimulus pushes hand-computed
// expectations into queues, independent monitors pop and compare on handshakes.
module tb_ace_snoop_port;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         acvalid = 1'b0;
  logic         acready;
  logic [31:0]  acaddr = '0;
  logic [3:0]   acsnoop = '0;
  logic [2:0]   acprot = '0;
  logic         crvalid;
  logic         crready = 1'b1;
  logic [4:0]   crresp;
  logic         cdvalid;
  logic         cdready;
  logic [31:0]  cddata;
  logic         cdlast;
  logic         lk_valid;
  logic         lk_ready = 1'b1;
  logic [31:0]  lk_addr;
  logic [3:0]   lk_snoop;
  logic         lk_rsp_valid;
  logic         lk_hit = 1'b0, lk_dirty = 1'b0, lk_unique = 1'b0;
  logic [127:0] lk_line = '0;

  logic rsp_cache = 1'b0, rsp_spur = 1'b0;
  logic tog_en = 1'b0, tog = 1'b1;
  assign lk_rsp_valid = rsp_cache | rsp_spur;
  assign cdready      = tog_en ? tog : 1'b1;

  int checks = 0;
  int errors = 0;
  int cd_beats = 0;

  logic [35:0]  exp_lk[$];
  logic [4:0]   exp_cr[$];
  logic [32:0]  exp_cd[$];
  logic [130:0] cache_q[$];

  ace_snoop_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_BEATS(4), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop), .acprot(acprot),
    .crvalid(crvalid), .crready(crready), .crresp(crresp),
    .cdvalid(cdvalid), .cdready(cdready), .cddata(cddata), .cdlast(cdlast),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_addr(lk_addr), .lk_snoop(lk_snoop),
    .lk_rsp_valid(lk_rsp_valid), .lk_hit(lk_hit), .lk_dirty(lk_dirty),
    .lk_unique(lk_unique), .lk_line(lk_line)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // called at posedge+1; leaves acvalid high so back-to-back calls are possible
  task automatic send_ac(input logic [31:0] addr, input logic [3:0] snoop);
    int n = 0;
    acvalid = 1'b1;
    acaddr  = addr;
    acsnoop = snoop;
    acprot  = 3'($urandom_range(0, 7));
    @(negedge clk);
    while (!acready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL ac_accept_timeout: got no acready expected acready within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [3:0] snoop, input logic lk,
                       input logic hit, input logic dirty, input logic uniq,
                       input logic [127:0] line, input logic [31:0] exp_lkaddr,
                       input logic [4:0] exp_resp);
    if (lk) begin
      exp_lk.push_back({exp_lkaddr, snoop});
      cache_q.push_back({hit, dirty, uniq, line});
    end
    exp_cr.push_back(exp_resp);
    if (exp_resp[0])
      for (int k = 0; k < 4; k++) exp_cd.push_back({(k == 3), line[k*32 +: 32]});
    send_ac(addr, snoop);
  endtask

  task automatic drain();
    int n = 0;
    acvalid = 1'b0;
    while ((exp_lk.size() + exp_cr.size() + exp_cd.size()) != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0",
               exp_lk.size() + exp_cr.size() + exp_cd.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // cache model: answers each accepted lookup one cycle later with a single-cycle pulse
  initial begin
    logic [130:0] cl;
    forever begin
      @(negedge clk);
      if (rst_n && lk_valid && lk_ready) begin
        cl = (cache_q.size() > 0) ? cache_q.pop_front() : '0;
        @(posedge clk);
        #1;
        rsp_cache = 1'b1;
        {lk_hit, lk_dirty, lk_unique, lk_line} = cl;
        @(posedge clk);
        #1;
        rsp_cache = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tog = tog_en ? ~tog : 1'b1;
    end
  end

  // monitor: compares every handshake against the queues and checks stall stability
  initial begin
    logic       cr_hold = 1'b0, cd_hold = 1'b0;
    logic [4:0] cr_hold_v = '0;
    logic [32:0] cd_hold_v = '0;
    logic [35:0] e36;
    logic [4:0]  e5;
    logic [32:0] e33;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cr_hold = 1'b0;
        cd_hold = 1'b0;
      end else begin
        if (cr_hold) begin
          chk("cr_held_valid", crvalid, 1'b1);
          chk("cr_held_resp", crresp, cr_hold_v);
        end
        if (cd_hold) begin
          chk("cd_held_valid", cdvalid, 1'b1);
          chk("cd_held_beat", {cdlast, cddata}, cd_hold_v);
        end
        if (lk_valid && lk_ready) begin
          if (exp_lk.size() == 0) begin
            checks++; errors++;
            $display("FAIL lk_unexpected: got addr %0h snoop %0h expected no lookup", lk_addr, lk_snoop);
          end else begin
            e36 = exp_lk.pop_front();
            chk("lk_addr_snoop", {lk_addr, lk_snoop}, e36);
          end
        end
        if (crvalid && crready) begin
          if (exp_cr.size() == 0) begin
            checks++; errors++;
            $display("FAIL cr_unexpected: got crresp %0h expected no response", crresp);
          end else begin
            e5 = exp_cr.pop_front();
            chk("crresp", crresp, e5);
          end
        end
        if (cdvalid && cdready) begin
          cd_beats++;
          if (exp_cd.size() == 0) begin
            checks++; errors++;
            $display("FAIL cd_unexpected: got cddata %0h expected no beat", cddata);
          end else begin
            e33 = exp_cd.pop_front();
            chk("cd_beat", {cdlast, cddata}, e33);
          end
        end
        cr_hold   = crvalid && !crready;
        cr_hold_v = crresp;
        cd_hold   = cdvalid && !cdready;
        cd_hold_v = {cdlast, cddata};
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int beats0;
    #12;
    chk("rst_acready", acready, 1'b0);
    chk("rst_crvalid", crvalid, 1'b0);
    chk("rst_cdvalid", cdvalid, 1'b0);
    chk("rst_cdlast", cdlast, 1'b0);
    chk("rst_lk_valid", lk_valid, 1'b0);
    chk("rst_crresp", crresp, 5'b00000);
    chk("rst_cddata", cddata, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("acready_after_reset", acready, 1'b1);
    @(posedge clk);
    #1;

    // basic snoop types, all readies high
    issue(32'h1004, 4'b0001, 1, 1, 1, 1, {32'h33, 32'h22, 32'h11, 32'h00}, 32'h1000, 5'b11101);
    drain();
    issue(32'h2010, 4'b1101, 1, 1, 1, 1, {32'h4, 32'h3, 32'h2, 32'h1}, 32'h2010, 5'b10000);
    issue(32'h203C, 4'b1101, 1, 1, 1, 0, {32'h8, 32'h7, 32'h6, 32'h5}, 32'h2030, 5'b00000);
    drain();
    issue(32'h3000, 4'b0000, 1, 1, 1, 0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 32'h3000, 5'b01001);
    issue(32'h4024, 4'b1001, 1, 1, 0, 1, {32'h0, 32'h0, 32'h0, 32'h9}, 32'h4020, 5'b10000);
    issue(32'h5008, 4'b1000, 1, 1, 1, 0, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 32'h5000, 5'b01101);
    drain();
    issue(32'h6000, 4'b0111, 1, 0, 1, 1, {32'h1, 32'h1, 32'h1, 32'h1}, 32'h6000, 5'b00000);
    issue(32'h7000, 4'b0101, 0, 0, 0, 0, 128'h0, 32'h0, 5'b00000);
    issue(32'h8014, 4'b0011, 1, 1, 1, 0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 32'h8010, 5'b01101);
    drain();

    // lookup result pulse while idle must be ignored
    rsp_spur = 1'b1;
    @(posedge clk);
    #1;
    rsp_spur = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("spurious_rsp_no_cr", crvalid, 1'b0);
    end
    @(posedge clk);
    #1;

    // CR backpressure fills the queue behind the stalled request
    crready = 1'b0;
    issue(32'h9000, 4'b0010, 1, 1, 1, 1, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 32'h9000, 5'b11001);
    issue(32'h9104, 4'b0000, 1, 0, 0, 0, 128'h0, 32'h9100, 5'b00000);
    issue(32'h9208, 4'b0011, 1, 1, 0, 1, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 32'h9200, 5'b11001);
    acvalid = 1'b0;
    @(negedge clk);
    chk("acready_full", acready, 1'b0);
    n = 0;
    while (!crvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cr_stalled_valid", crvalid, 1'b1);
    repeat (3) @(negedge clk);
    chk("acready_still_full", acready, 1'b0);
    @(posedge clk);
    #1;
    crready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!acready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("acready_rise_with_lookup", {acready, lk_valid}, 2'b11);
    @(posedge clk);
    #1;
    drain();

    // CD backpressure: cdready alternates during the data phase
    tog_en = 1'b1;
    beats0 = cd_beats;
    issue(32'hA000, 4'b0001, 1, 1, 0, 0, {32'h5A3, 32'h5A2, 32'h5A1, 32'h5A0}, 32'hA000, 5'b01001);
    drain();
    chk("toggle_beat_count", cd_beats - beats0, 4);
    tog_en = 1'b0;
    @(posedge clk);
    #1;

    // reset while beat 2 is on the bus
    beats0 = cd_beats;
    issue(32'hB008, 4'b0001, 1, 1, 1, 1, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 32'hB000, 5'b11101);
    acvalid = 1'b0;
    n = 0;
    while (!(cdvalid && cddata == 32'hC2) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_beat2", {cdvalid, cddata}, {1'b1, 32'hC2});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cdvalid", cdvalid, 1'b0);
    chk("rst_mid_crvalid", crvalid, 1'b0);
    chk("rst_mid_acready", acready, 1'b0);
    chk("beats_before_reset", cd_beats - beats0, 2);
    exp_lk.delete();
    exp_cr.delete();
    exp_cd.delete();
    cache_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("acready_after_mid_reset", acready, 1'b1);
    repeat (10) @(negedge clk);
    chk("no_residual_beats", cd_beats - beats0, 2);
    @(posedge clk);
    #1;
    issue(32'hC000, 4'b0111, 1, 1, 0, 1, {32'h73, 32'h72, 32'h71, 32'h70}, 32'hC000, 5'b10001);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
